// File: rtl/memory_bus_arbiter.sv
// Shares one cyc/stb/ack memory bus between the instruction-fetch port and
// the data port. One bus cycle runs at a time, and the data port wins ties.
// Each port keeps a done flag and a read buffer that holds its value until
// the owning pipeline stage advances. A flushed cycle is drained and its
// result discarded. A cycle that never sees ack is force-terminated.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no bus cycle; arbitrate among pending ports
// ST_IBUS  | fetch port owns the bus
// ST_DBUS  | data port owns the bus
// ST_DRAIN | flushed cycle still open; wait for ack or timeout, discard
module memory_bus_arbiter #(
  parameter int unsigned BUS_TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_input,
  input  logic [5:0]  stop_all,
  input  logic        if_request_input,
  input  logic [31:0] if_address_input,
  output logic [31:0] if_data_output,
  output logic        if_stall_request,
  input  logic        mem_request_input,
  input  logic        mem_we_input,
  input  logic [3:0]  mem_sel_input,
  input  logic [31:0] mem_address_input,
  input  logic [31:0] mem_data_input,
  output logic [31:0] mem_data_output,
  output logic        mem_stall_request,
  output logic        bus_cyc_output,
  output logic        bus_stb_output,
  output logic        bus_we_output,
  output logic [3:0]  bus_sel_output,
  output logic [31:0] bus_address_output,
  output logic [31:0] bus_data_output,
  input  logic [31:0] bus_data_input,
  input  logic        bus_ack_input,
  output logic        bus_timeout_output
);

  typedef enum logic [1:0] {ST_IDLE, ST_IBUS, ST_DBUS, ST_DRAIN} state_t;

  // The counter value seen at the edge that ends the BUS_TIMEOUT_CYCLES-th cycle.
  localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_buf_q, if_buf_d;
  logic [31:0] mem_buf_q, mem_buf_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        tmo_q, tmo_d;

  logic if_pend, mem_pend, cnt_hit;

  // Only the IF and MEM stall bits matter to this block.
  logic unused_stop;
  assign unused_stop = ^{stop_all[5], stop_all[3:2], stop_all[0]};

  assign if_pend  = if_request_input & ~if_done_q;
  assign mem_pend = mem_request_input & ~mem_done_q;
  assign cnt_hit  = (cnt_q == CNT_LAST);

  assign if_stall_request   = if_pend;
  assign mem_stall_request  = mem_pend;
  assign if_data_output     = if_buf_q;
  assign mem_data_output    = mem_buf_q;
  // cyc and stb always move together, so a single flop drives both.
  assign bus_cyc_output     = cyc_q;
  assign bus_stb_output     = cyc_q;
  assign bus_we_output      = we_q;
  assign bus_sel_output     = sel_q;
  assign bus_address_output = adr_q;
  assign bus_data_output    = dat_q;
  assign bus_timeout_output = tmo_q;

  // Arbitration, bus cycle sequencing, done flags and buffer loads.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_buf_d   = if_buf_q;
    mem_buf_d  = mem_buf_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tmo_d      = 1'b0;
    // A done flag survives only while its request is held and its stage is stopped.
    if_done_d  = if_done_q & if_request_input & stop_all[1];
    mem_done_d = mem_done_q & mem_request_input & stop_all[4];

    unique case (state_q)
      ST_IDLE: begin
        if (!flush_input) begin
          if (mem_pend) begin
            state_d = ST_DBUS;
            cyc_d   = 1'b1;
            we_d    = mem_we_input;
            sel_d   = mem_sel_input;
            adr_d   = mem_address_input;
            dat_d   = mem_data_input;
            cnt_d   = '0;
          end else if (if_pend) begin
            state_d = ST_IBUS;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = 4'b1111;
            adr_d   = if_address_input;
            dat_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_IBUS, ST_DBUS: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack_input) begin
          cyc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!flush_input) begin
            if (state_q == ST_IBUS) begin
              if_done_d = 1'b1;
              if_buf_d  = bus_data_input;
            end else begin
              mem_done_d = 1'b1;
              mem_buf_d  = bus_data_input;
            end
          end
        end else if (cnt_hit) begin
          cyc_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
          if (!flush_input) begin
            if (state_q == ST_IBUS) begin
              if_done_d = 1'b1;
              if_buf_d  = '0;
            end else begin
              mem_done_d = 1'b1;
              mem_buf_d  = '0;
            end
          end
        end else if (flush_input) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack_input) begin
          cyc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_hit) begin
          cyc_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_input) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
  end

  // State, flags, buffers and registered bus outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_buf_q   <= '0;
      mem_buf_q  <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_buf_q   <= if_buf_d;
      mem_buf_q  <= mem_buf_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter. A scripted bus slave acks each bus cycle
// after a queued number of wait states and logs every cycle it sees.
// Expectations come from transaction-level arithmetic: stall lengths,
// arbitration order, buffered data values and timeout lengths.
module tb_memory_bus_arbiter;
  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush_input = 1'b0;
  logic [5:0]  stop_all = '0;
  logic        if_request_input = 1'b0;
  logic [31:0] if_address_input = '0;
  logic [31:0] if_data_output;
  logic        if_stall_request;
  logic        mem_request_input = 1'b0;
  logic        mem_we_input = 1'b0;
  logic [3:0]  mem_sel_input = '0;
  logic [31:0] mem_address_input = '0;
  logic [31:0] mem_data_input = '0;
  logic [31:0] mem_data_output;
  logic        mem_stall_request;
  logic        bus_cyc_output, bus_stb_output, bus_we_output;
  logic [3:0]  bus_sel_output;
  logic [31:0] bus_address_output, bus_data_output;
  logic [31:0] bus_data_input = '0;
  logic        bus_ack_input = 1'b0;
  logic        bus_timeout_output;

  memory_bus_arbiter #(.BUS_TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .flush_input(flush_input), .stop_all(stop_all),
    .if_request_input(if_request_input), .if_address_input(if_address_input),
    .if_data_output(if_data_output), .if_stall_request(if_stall_request),
    .mem_request_input(mem_request_input), .mem_we_input(mem_we_input),
    .mem_sel_input(mem_sel_input), .mem_address_input(mem_address_input),
    .mem_data_input(mem_data_input), .mem_data_output(mem_data_output),
    .mem_stall_request(mem_stall_request),
    .bus_cyc_output(bus_cyc_output), .bus_stb_output(bus_stb_output),
    .bus_we_output(bus_we_output), .bus_sel_output(bus_sel_output),
    .bus_address_output(bus_address_output), .bus_data_output(bus_data_output),
    .bus_data_input(bus_data_input), .bus_ack_input(bus_ack_input),
    .bus_timeout_output(bus_timeout_output)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          len;
    bit          stable;
  } bc_t;

  int          total = 0;
  int          bad = 0;
  int          cyc_no = 0;
  int          wq_wait[$];
  logic [31:0] wq_data[$];
  bc_t         bc_log[$];
  int          tmo_log[$];
  bc_t         cur;
  bit          prev_cyc = 0;
  int          cur_wait = -1;
  logic [31:0] cur_rdata = '0;
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_mem_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance past the edge, then let the slave react to the bus.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc_no++;
    if (bus_timeout_output) tmo_log.push_back(cyc_no);
    if (bus_cyc_output) begin
      if (!prev_cyc) begin
        cur.addr   = bus_address_output;
        cur.we     = bus_we_output;
        cur.sel    = bus_sel_output;
        cur.wdata  = bus_data_output;
        cur.len    = 0;
        cur.stable = 1;
        if (wq_wait.size() > 0) begin
          cur_wait  = wq_wait.pop_front();
          cur_rdata = wq_data.pop_front();
        end else begin
          cur_wait  = -1;
          cur_rdata = '0;
        end
      end else if (bus_address_output !== cur.addr || bus_we_output !== cur.we ||
                   bus_sel_output !== cur.sel || bus_data_output !== cur.wdata) begin
        cur.stable = 0;
      end
      if (bus_stb_output !== 1'b1) cur.stable = 0;
      cur.len++;
      if (cur.len - 1 == cur_wait) begin
        bus_ack_input  = 1'b1;
        bus_data_input = cur_rdata;
      end else begin
        bus_ack_input  = 1'b0;
        bus_data_input = $urandom | 32'h1;
      end
    end else begin
      if (prev_cyc) bc_log.push_back(cur);
      bus_ack_input  = 1'b0;
      bus_data_input = $urandom | 32'h1;
    end
    prev_cyc = bus_cyc_output;
  endtask

  task automatic idle_all();
    if_request_input  = 1'b0;
    mem_request_input = 1'b0;
    stop_all          = '0;
    flush_input       = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic stall_of(input bit is_mem);
    return is_mem ? mem_stall_request : if_stall_request;
  endfunction

  // One access on one port; stall must last waits+2 cycles.
  task automatic run_single(input bit is_mem, input bit we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits);
    int n;
    int base;
    bc_t e;
    base = bc_log.size();
    wq_wait.push_back(waits);
    wq_data.push_back(rdata);
    if (is_mem) begin
      mem_request_input = 1'b1;
      mem_we_input      = we;
      mem_sel_input     = sel;
      mem_address_input = addr;
      mem_data_input    = wdata;
      stop_all          = 6'b010000;
    end else begin
      if_request_input = 1'b1;
      if_address_input = addr;
      stop_all         = 6'b000010;
    end
    #1;
    n = 0;
    while (stall_of(is_mem) && n < 60) begin
      n++;
      tick();
      #1;
    end
    check_eq("stall_len", 32'(n), 32'(waits + 2));
    if (is_mem) exp_mem_data = rdata;
    else        exp_if_data  = rdata;
    check_eq("mem_data", mem_data_output, exp_mem_data);
    check_eq("if_data", if_data_output, exp_if_data);
    check_eq("cyc_after", {31'b0, bus_cyc_output}, 32'd0);
    check_eq("bus_cnt", 32'(bc_log.size() - base), 32'd1);
    if (bc_log.size() > base) begin
      e = bc_log[base];
      check_eq("bus_addr", e.addr, addr);
      check_eq("bus_we", {31'b0, e.we}, {31'b0, is_mem & we});
      check_eq("bus_sel", {28'b0, e.sel}, is_mem ? {28'b0, sel} : 32'hF);
      if (is_mem && we) check_eq("bus_wdata", e.wdata, wdata);
      check_eq("bus_len", 32'(e.len), 32'(waits + 1));
      check_eq("bus_stable", {31'b0, e.stable}, 32'd1);
    end
    // Stage still stopped with request held: no new cycle may start.
    tick();
    #1;
    check_eq("hold_stall", {31'b0, stall_of(is_mem)}, 32'd0);
    check_eq("hold_cyc", {31'b0, bus_cyc_output}, 32'd0);
    idle_all();
    #1;
    check_eq("keep_data", is_mem ? mem_data_output : if_data_output, rdata);
  endtask

  // Both ports request together; data port goes first, IF after one idle cycle.
  task automatic run_both(input logic [31:0] iaddr, input logic [31:0] maddr,
                          input int iw, input int mw,
                          input logic [31:0] ird, input logic [31:0] mrd);
    int n_if, n_mem, g, base;
    base = bc_log.size();
    wq_wait.push_back(mw);
    wq_data.push_back(mrd);
    wq_wait.push_back(iw);
    wq_data.push_back(ird);
    if_request_input  = 1'b1;
    if_address_input  = iaddr;
    mem_request_input = 1'b1;
    mem_we_input      = 1'b0;
    mem_sel_input     = 4'b1111;
    mem_address_input = maddr;
    stop_all          = 6'b010010;
    #1;
    n_if = 0; n_mem = 0; g = 0;
    while ((if_stall_request || mem_stall_request) && g < 80) begin
      g++;
      if (if_stall_request) n_if++;
      if (mem_stall_request) n_mem++;
      tick();
      #1;
    end
    check_eq("both_mem_stall", 32'(n_mem), 32'(mw + 2));
    check_eq("both_if_stall", 32'(n_if), 32'(mw + iw + 4));
    check_eq("both_cnt", 32'(bc_log.size() - base), 32'd2);
    if (bc_log.size() >= base + 2) begin
      check_eq("both_first", bc_log[base].addr, maddr);
      check_eq("both_second", bc_log[base + 1].addr, iaddr);
    end
    exp_mem_data = mrd;
    exp_if_data  = ird;
    check_eq("both_mem_data", mem_data_output, exp_mem_data);
    check_eq("both_if_data", if_data_output, exp_if_data);
    idle_all();
  endtask

  initial begin
    int n, g, base;
    bit flushed, drain_seen;
    logic [31:0] r1, r2;

    // Reset values, and stalls following requests while in reset.
    tick();
    tick();
    #1;
    check_eq("rst_cyc", {31'b0, bus_cyc_output}, 32'd0);
    check_eq("rst_stb", {31'b0, bus_stb_output}, 32'd0);
    check_eq("rst_we", {31'b0, bus_we_output}, 32'd0);
    check_eq("rst_sel", {28'b0, bus_sel_output}, 32'd0);
    check_eq("rst_addr", bus_address_output, 32'd0);
    check_eq("rst_bdata", bus_data_output, 32'd0);
    check_eq("rst_tmo", {31'b0, bus_timeout_output}, 32'd0);
    check_eq("rst_if_data", if_data_output, 32'd0);
    check_eq("rst_mem_data", mem_data_output, 32'd0);
    check_eq("rst_if_stall0", {31'b0, if_stall_request}, 32'd0);
    if_request_input  = 1'b1;
    mem_request_input = 1'b1;
    #1;
    check_eq("rst_if_stall1", {31'b0, if_stall_request}, 32'd1);
    check_eq("rst_mem_stall1", {31'b0, mem_stall_request}, 32'd1);
    if_request_input  = 1'b0;
    mem_request_input = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Directed: read with one wait state, then a partial write.
    run_single(1, 0, 4'b1111, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1);
    run_single(1, 1, 4'b0011, 32'h0000_2004, 32'h1234_5678, 32'h0BAD_F00D, 2);
    run_single(0, 0, 4'b0000, 32'h0040_0000, 32'h0, 32'h2402_0001, 0);

    // Randomized single-port accesses.
    for (int i = 0; i < 24; i++) begin
      run_single(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, 5)));
    end

    // Simultaneous requests: zero-wait directed, then random waits.
    run_both(32'h0040_0010, 32'h1000_0020, 0, 0, 32'h1111_1111, 32'h2222_2222);
    for (int i = 0; i < 4; i++) begin
      run_both($urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom, $urandom);
    end

    // Flush during a 5-wait-state fetch: drained, discarded, then refetched.
    r1 = 32'hAAAA_5555;
    r2 = 32'h0F0F_F0F0;
    base = bc_log.size();
    wq_wait.push_back(5); wq_data.push_back(r1);
    wq_wait.push_back(0); wq_data.push_back(r2);
    if_request_input = 1'b1;
    if_address_input = 32'h0040_0100;
    stop_all         = 6'b000010;
    #1;
    n = 0; flushed = 0; drain_seen = 0;
    while (if_stall_request && n < 80) begin
      n++;
      if (bus_cyc_output && !flushed && cur.len == 2) begin
        flush_input = 1'b1;
        flushed = 1;
      end
      tick();
      flush_input = 1'b0;
      #1;
      if (!drain_seen && bc_log.size() == base + 1) begin
        drain_seen = 1;
        check_eq("drain_no_update", if_data_output, exp_if_data);
        check_eq("drain_stalled", {31'b0, if_stall_request}, 32'd1);
      end
    end
    check_eq("flush_stall_len", 32'(n), 32'd9);
    check_eq("flush_cnt", 32'(bc_log.size() - base), 32'd2);
    if (bc_log.size() >= base + 2) begin
      check_eq("flush_drain_len", 32'(bc_log[base].len), 32'd6);
      check_eq("flush_refetch_addr", bc_log[base + 1].addr, 32'h0040_0100);
    end
    exp_if_data = r2;
    check_eq("flush_data", if_data_output, exp_if_data);
    idle_all();

    // Ack never arrives: forced termination after TMO cycles.
    base = bc_log.size();
    tmo_log.delete();
    wq_wait.push_back(-1); wq_data.push_back(32'h0);
    mem_request_input = 1'b1;
    mem_we_input      = 1'b0;
    mem_sel_input     = 4'b1111;
    mem_address_input = 32'h1000_0040;
    stop_all          = 6'b010000;
    #1;
    n = 0;
    while (mem_stall_request && n < 60) begin
      n++;
      tick();
      #1;
    end
    check_eq("tmo_stall_len", 32'(n), 32'(TMO + 1));
    check_eq("tmo_data", mem_data_output, 32'd0);
    check_eq("tmo_pulse_cnt", 32'(tmo_log.size()), 32'd1);
    if (tmo_log.size() > 0) check_eq("tmo_pulse_when", 32'(tmo_log[0]), 32'(cyc_no));
    if (bc_log.size() > base) check_eq("tmo_cyc_len", 32'(bc_log[base].len), 32'(TMO));
    tick();
    #1;
    check_eq("tmo_pulse_end", {31'b0, bus_timeout_output}, 32'd0);
    check_eq("tmo_pulse_cnt2", 32'(tmo_log.size()), 32'd1);
    exp_mem_data = 32'd0;
    idle_all();

    // Reset in the middle of a write; the same request restarts afterwards.
    base = bc_log.size();
    wq_wait.push_back(5); wq_data.push_back(32'h5A5A_5A5A);
    wq_wait.push_back(1); wq_data.push_back(32'hC0DE_CAFE);
    mem_request_input = 1'b1;
    mem_we_input      = 1'b1;
    mem_sel_input     = 4'b1100;
    mem_address_input = 32'h1000_0080;
    mem_data_input    = 32'h7777_8888;
    stop_all          = 6'b010000;
    #1;
    g = 0;
    while (!(bus_cyc_output && cur.len == 3) && g < 20) begin
      g++;
      tick();
      #1;
    end
    check_eq("pre_rst_we", {31'b0, bus_we_output}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_cyc", {31'b0, bus_cyc_output}, 32'd0);
    check_eq("mid_rst_stb", {31'b0, bus_stb_output}, 32'd0);
    check_eq("mid_rst_we", {31'b0, bus_we_output}, 32'd0);
    check_eq("mid_rst_tmo", {31'b0, bus_timeout_output}, 32'd0);
    check_eq("mid_rst_stall", {31'b0, mem_stall_request}, 32'd1);
    exp_if_data  = 32'd0;
    exp_mem_data = 32'd0;
    check_eq("mid_rst_if_data", if_data_output, exp_if_data);
    tick();
    tick();
    reset = 1'b1;
    #1;
    n = 0;
    while (mem_stall_request && n < 60) begin
      n++;
      tick();
      #1;
    end
    check_eq("rst_restart_stall", 32'(n), 32'd3);
    check_eq("rst_restart_cnt", 32'(bc_log.size() - base), 32'd2);
    if (bc_log.size() >= base + 2) begin
      check_eq("rst_restart_addr", bc_log[base + 1].addr, 32'h1000_0080);
      check_eq("rst_restart_we", {31'b0, bc_log[base + 1].we}, 32'd1);
      check_eq("rst_restart_wdata", bc_log[base + 1].wdata, 32'h7777_8888);
    end
    exp_mem_data = 32'hC0DE_CAFE;
    check_eq("rst_restart_data", mem_data_output, exp_mem_data);
    idle_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the single external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage, fed by the EX/MEM pipeline register). It runs a registered cyc/stb/ack bus cycle for one port at a time and raises per-port stall requests toward the pipeline controller. Returned read data is buffered until the owning stage advances. On a pipeline flush, any in-flight bus cycle is drained and its result discarded.

## Interface
- BUS_TIMEOUT_CYCLES, 255: cycles without ack before an active bus cycle is force-terminated; 8-bit counter.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- flush_input  in  1  pipeline flush (exception/eret)
- stop_all  in  6  pipeline stall bus; bit1 = IF stalled, bit4 = MEM stalled, 1 = Stop
- if_request_input  in  1  IF port wants a read
- if_address_input  in  32  fetch address
- if_data_output  out  32  buffered fetch data
- if_stall_request  out  1  IF port not yet satisfied
- mem_request_input  in  1  data port access request
- mem_we_input  in  1  1 = write
- mem_sel_input  in  4  byte enables
- mem_address_input  in  32  data address
- mem_data_input  in  32  store data
- mem_data_output  out  32  buffered load data
- mem_stall_request  out  1  data port not yet satisfied
- bus_cyc_output, bus_stb_output  out  1 each  bus cycle/strobe
- bus_we_output  out  1;  bus_sel_output  out  4;  bus_address_output  out  32;  bus_data_output  out  32
- bus_data_input  in  32;  bus_ack_input  in  1
- bus_timeout_output  out  1  one-cycle pulse on forced termination

## Operation
- States: IDLE, IBUS (IF owns bus), DBUS (data port owns bus), DRAIN (flushed cycle finishing).
- Per-port done flag plus 32-bit data buffer.
- if_stall_request = if_request_input & ~if_done. mem_stall_request = mem_request_input & ~mem_done. Both are combinational.
- IDLE:
  - Pending port = request high and done low.
  - If the data port is pending, go to DBUS. Else if the IF port is pending, go to IBUS.
  - Data port wins any simultaneous request. There is no preemption once a cycle starts.
- On entry to IBUS/DBUS, register all bus outputs from the winning port:
  - cyc = stb = 1.
  - IF cycles use we = 0 and sel = 4'b1111.
  - Address, data, we and sel are held stable until the cycle ends.
- IBUS/DBUS with ack high at an edge:
  - Deassert cyc/stb.
  - Set the owner's done flag.
  - Latch bus_data_input into the owner's buffer (writes latch it too; the value is ignored).
  - Return to IDLE.
- Done flag clears at an edge where the request is low, or where the owning stage advances: stop_all[1] = 0 for IF, stop_all[4] = 0 for MEM. A cleared flag lets a new request start. The buffer keeps its value.
- Flush (flush_input = 1 at an edge):
  - Both done flags clear.
  - IBUS/DBUS go to DRAIN. Bus outputs stay asserted until ack, then the state returns to IDLE with no buffer or done update.
  - Flush in IDLE or DRAIN only clears the flags.
  - Flush has priority over ack in the same cycle: the state goes IDLE and the result is discarded.
- Timeout:
  - Counter resets on entering IBUS/DBUS and on ack; it increments each cycle in IBUS/DBUS/DRAIN.
  - When it reaches BUS_TIMEOUT_CYCLES: drop cyc/stb and pulse bus_timeout_output.
  - From IBUS/DBUS: set the owner's done flag and load its buffer with 0.
  - From DRAIN: go to IDLE only.
- Reset: state IDLE, counter 0, both done flags 0, both buffers 0, every registered bus output 0, bus_timeout_output 0. Stall outputs then follow their requests. Reset mid-cycle drops cyc/stb immediately.

## Timing
- Zero-wait-state slave (ack in the first cycle cyc is high):
  - Request seen in cycle 0; cyc/stb high in cycle 1; ack in cycle 1.
  - Data buffered and stall low in cycle 2.
  - Stall lasts 2 cycles.
- N wait states add N cycles.
- Back-to-back cycles: at least one IDLE cycle (cyc low) separates bus cycles.
- Data is valid on if_data_output / mem_data_output from the cycle stall falls until the next buffer load.
- bus_timeout_output is high for exactly the one cycle after the terminating edge.

## Test plan
- Data read, ack one cycle after stb → mem_stall_request high exactly 3 cycles; mem_data_output = 0xDEADBEEF on the cycle stall falls.
- IF and data requests in the same cycle → data cycle first (bus_address_output = data address), IF cycle starts after one idle cycle; if_stall_request high 4 cycles with zero-wait acks.
- Write, sel = 4'b0011, data 0x12345678 → bus_we_output = 1 and bus_sel_output = 0011 held until ack; mem_stall_request falls the cycle after ack.
- flush_input during a 5-wait-state IF cycle → cyc stays high until ack; if_done remains 0; no buffer update; an IF request after the flush stays stalled until its new cycle completes.
- Ack never arrives, BUS_TIMEOUT_CYCLES = 4 → cyc drops 4 cycles after its rise; one-cycle bus_timeout_output pulse; mem_data_output = 0; stall released.
- Reset asserted mid-cycle → cyc/stb/we/timeout go 0 immediately; the same request restarts a full bus cycle after reset deasserts.
